// File: rtl/fp32_arith_unit.sv
// Binary32 add/multiply unit with stb/ack handshakes, fixed latency, RNE rounding, FTZ.
// Build option: define FP_MUL_EN to compile in the multiply path (otherwise add-only).
module fp32_arith_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_mul,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  input  logic [31:0] input_b,
  input  logic        input_b_stb,
  output logic        input_b_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  typedef enum logic [3:0] {
    StGetA, StGetB, StUnpack, StSpecial, StOp, StNorm, StRound, StPack, StPutZ
  } state_e;

  localparam logic [31:0] QNaN = 32'h7FC0_0000;

  state_e             state_q;
  logic               a_ack_q, b_ack_q, z_stb_q;
  logic [31:0]        z_q, a_q, b_q;
  logic               sa_q, sb_q;
  logic signed [9:0]  ea_q, eb_q;
  logic [23:0]        ma_q, mb_q;
  logic               spec_q;
  logic [31:0]        spec_z_q;
  logic               sign_q;
  logic signed [9:0]  exp_q;
  logic [47:0]        mant_q;
  logic [23:0]        m24_q;
  logic               guard_q, round_q, sticky_q;

`ifdef FP_MUL_EN
  logic               op_q;
`else
  logic               unused_op_mul;
  assign unused_op_mul = op_mul;
`endif

  assign input_a_ack  = a_ack_q;
  assign input_b_ack  = b_ack_q;
  assign output_z     = z_q;
  assign output_z_stb = z_stb_q;

  // Operand classification straight from the captured words
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  assign a_nan  = (&a_q[30:23]) & (|a_q[22:0]);
  assign b_nan  = (&b_q[30:23]) & (|b_q[22:0]);
  assign a_inf  = (&a_q[30:23]) & ~(|a_q[22:0]);
  assign b_inf  = (&b_q[30:23]) & ~(|b_q[22:0]);
  assign a_zero = ~(|a_q[30:23]);
  assign b_zero = ~(|b_q[30:23]);

  logic        spec_d;
  logic [31:0] spec_z_d;
  always_comb begin
    spec_d   = 1'b0;
    spec_z_d = 32'h0;
    if (a_nan || b_nan) begin
      spec_d   = 1'b1;
      spec_z_d = QNaN;
    end else
`ifdef FP_MUL_EN
    if (op_q) begin
      if ((a_inf && b_zero) || (b_inf && a_zero)) begin
        spec_d   = 1'b1;
        spec_z_d = QNaN;
      end else if (a_inf || b_inf) begin
        spec_d   = 1'b1;
        spec_z_d = {a_q[31] ^ b_q[31], 8'hFF, 23'h0};
      end else if (a_zero || b_zero) begin
        spec_d   = 1'b1;
        spec_z_d = {a_q[31] ^ b_q[31], 31'h0};
      end
    end else
`endif
    begin
      if (a_inf && b_inf && (a_q[31] != b_q[31])) begin
        spec_d   = 1'b1;
        spec_z_d = QNaN;
      end else if (a_inf) begin
        spec_d   = 1'b1;
        spec_z_d = a_q;
      end else if (b_inf) begin
        spec_d   = 1'b1;
        spec_z_d = b_q;
      end
    end
  end

  // Operation stage: result is mant_d * 2^(exp_d - 46) for both add and multiply
  logic              a_big, big_s, small_s;
  logic [23:0]       big_m, small_m;
  logic signed [9:0] big_e, small_e, exp_diff;
  logic [4:0]        shamt;
  logic [63:0]       align;
  logic [26:0]       small_al;
  logic [27:0]       add_sum;
  logic              sign_d;
  logic signed [9:0] exp_d;
  logic [47:0]       mant_d;
  always_comb begin
    a_big    = (ea_q > eb_q) || ((ea_q == eb_q) && (ma_q >= mb_q));
    big_m    = a_big ? ma_q : mb_q;
    small_m  = a_big ? mb_q : ma_q;
    big_e    = a_big ? ea_q : eb_q;
    small_e  = a_big ? eb_q : ea_q;
    big_s    = a_big ? sa_q : sb_q;
    small_s  = a_big ? sb_q : sa_q;
    exp_diff = big_e - small_e;
    shamt    = (exp_diff > 10'sd31) ? 5'd31 : exp_diff[4:0];
    align    = {small_m, 40'd0} >> shamt;
    // Everything shifted past the round bit collapses into the sticky LSB
    small_al = {align[63:38], align[37] | (|align[36:0])};
    if (big_s == small_s) add_sum = {1'b0, big_m, 3'b000} + {1'b0, small_al};
    else                  add_sum = {1'b0, big_m, 3'b000} - {1'b0, small_al};
    // Exact cancellation of opposite signs yields +0
    sign_d = ((add_sum == 28'd0) && (big_s != small_s)) ? 1'b0 : big_s;
    exp_d  = big_e;
    mant_d = {add_sum, 20'd0};
`ifdef FP_MUL_EN
    if (op_q) begin
      sign_d = sa_q ^ sb_q;
      exp_d  = ea_q + eb_q;
      mant_d = {24'd0, ma_q} * {24'd0, mb_q};
    end
`endif
  end

  logic [5:0]        lead;
  logic [47:0]       norm;
  logic signed [9:0] exp_n;
  always_comb begin
    lead = 6'd0;
    for (int i = 0; i < 48; i++) begin
      if (mant_q[i]) lead = 6'(i);
    end
    norm  = mant_q << (6'd47 - lead);
    exp_n = exp_q + $signed({4'b0000, lead}) - 10'sd46;
  end

  logic        inc;
  logic [24:0] rsum;
  assign inc  = guard_q & (round_q | sticky_q | m24_q[0]);
  assign rsum = {1'b0, m24_q} + {24'd0, inc};

  logic [7:0]  bexp;
  logic [31:0] pack_z;
  assign bexp = exp_q[7:0] + 8'd127;
  always_comb begin
    if (spec_q)                  pack_z = spec_z_q;
    else if (m24_q == 24'd0)     pack_z = {sign_q, 31'h0};
    else if (exp_q > 10'sd127)   pack_z = {sign_q, 8'hFF, 23'h0};
    else if (exp_q < -10'sd126)  pack_z = {sign_q, 31'h0};
    else                         pack_z = {sign_q, bexp, m24_q[22:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StGetA;
      a_ack_q  <= 1'b0;
      b_ack_q  <= 1'b0;
      z_stb_q  <= 1'b0;
      z_q      <= 32'h0;
      a_q      <= 32'h0;
      b_q      <= 32'h0;
`ifdef FP_MUL_EN
      op_q     <= 1'b0;
`endif
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      ea_q     <= 10'sd0;
      eb_q     <= 10'sd0;
      ma_q     <= 24'd0;
      mb_q     <= 24'd0;
      spec_q   <= 1'b0;
      spec_z_q <= 32'h0;
      sign_q   <= 1'b0;
      exp_q    <= 10'sd0;
      mant_q   <= 48'd0;
      m24_q    <= 24'd0;
      guard_q  <= 1'b0;
      round_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      unique case (state_q)
        StGetA: begin
          a_ack_q <= 1'b1;
          if (a_ack_q && input_a_stb) begin
            a_q     <= input_a;
`ifdef FP_MUL_EN
            op_q    <= op_mul;
`endif
            a_ack_q <= 1'b0;
            state_q <= StGetB;
          end
        end
        StGetB: begin
          b_ack_q <= 1'b1;
          if (b_ack_q && input_b_stb) begin
            b_q     <= input_b;
            b_ack_q <= 1'b0;
            state_q <= StUnpack;
          end
        end
        StUnpack: begin
          // Denormals become signed zero with a below-normal exponent
          sa_q    <= a_q[31];
          sb_q    <= b_q[31];
          ea_q    <= a_zero ? -10'sd127 : $signed({2'b00, a_q[30:23]}) - 10'sd127;
          eb_q    <= b_zero ? -10'sd127 : $signed({2'b00, b_q[30:23]}) - 10'sd127;
          ma_q    <= a_zero ? 24'd0 : {1'b1, a_q[22:0]};
          mb_q    <= b_zero ? 24'd0 : {1'b1, b_q[22:0]};
          state_q <= StSpecial;
        end
        StSpecial: begin
          spec_q   <= spec_d;
          spec_z_q <= spec_z_d;
          state_q  <= StOp;
        end
        StOp: begin
          sign_q  <= sign_d;
          exp_q   <= exp_d;
          mant_q  <= mant_d;
          state_q <= StNorm;
        end
        StNorm: begin
          m24_q    <= norm[47:24];
          guard_q  <= norm[23];
          round_q  <= norm[22];
          sticky_q <= |norm[21:0];
          exp_q    <= exp_n;
          state_q  <= StRound;
        end
        StRound: begin
          if (rsum[24]) begin
            m24_q <= rsum[24:1];
            exp_q <= exp_q + 10'sd1;
          end else begin
            m24_q <= rsum[23:0];
          end
          state_q <= StPack;
        end
        StPack: begin
          z_q     <= pack_z;
          z_stb_q <= 1'b1;
          state_q <= StPutZ;
        end
        StPutZ: begin
          if (z_stb_q && output_z_ack) begin
            z_stb_q <= 1'b0;
            a_ack_q <= 1'b1;
            state_q <= StGetA;
          end
        end
        default: state_q <= StGetA;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_arith_unit.sv
// Scoreboard bench for fp32_arith_unit: random and directed operands against a real-valued model.
module tb_fp32_arith_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_mul;
  logic [31:0] input_a, input_b, output_z;
  logic        input_a_stb, input_a_ack, input_b_stb, input_b_ack;
  logic        output_z_stb, output_z_ack;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int          hold_req = 0;
  logic [31:0] exp_z[$];
  int unsigned exp_t[$];

  fp32_arith_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .op_mul       (op_mul),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .input_b      (input_b),
    .input_b_stb  (input_b_stb),
    .input_b_ack  (input_b_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // ---------------- reference model (double-precision arithmetic) ----------------
  function automatic real f2r(input logic [31:0] f);
    logic [10:0] e11;
    logic [63:0] d;
    e11 = {3'b000, f[30:23]} + 11'd896;
    if (f[30:23] == 8'h00) d = {f[31], 63'h0};
    else                   d = {f[31], e11, f[22:0], 29'h0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [52:0] m;
    logic [24:0] k;
    logic [28:0] rem;
    int          e;
    d = $realtobits(r);
    if (d[62:0] == 63'h0) return {d[63], 31'h0};
    e   = int'({21'h0, d[62:52]}) - 1023;
    m   = {1'b1, d[51:0]};
    k   = {1'b0, m[52:29]};
    rem = m[28:0];
    if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && k[0])) k = k + 25'd1;
    if (k[24]) begin
      k = k >> 1;
      e++;
    end
    if (e > 127)  return {d[63], 8'hFF, 23'h0};
    if (e < -126) return {d[63], 31'h0};
    return {d[63], 8'(e + 127), k[22:0]};
  endfunction

  function automatic logic [31:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic mul);
    logic an, bn, ai, bi, az, bz;
    real  r;
    an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    az = (a[30:23] == 8'h00);
    bz = (b[30:23] == 8'h00);
    if (an || bn) return 32'h7FC0_0000;
    if (mul) begin
      if ((ai && bz) || (bi && az)) return 32'h7FC0_0000;
      if (ai || bi) return {a[31] ^ b[31], 8'hFF, 23'h0};
      if (az || bz) return {a[31] ^ b[31], 31'h0};
      return r2f(f2r(a) * f2r(b));
    end
    if (ai && bi && (a[31] != b[31])) return 32'h7FC0_0000;
    if (ai) return a;
    if (bi) return b;
    r = f2r(a) + f2r(b);
    if (r == 0.0) return (az && bz && a[31] && b[31]) ? 32'h8000_0000 : 32'h0;
    return r2f(r);
  endfunction

  function automatic logic eff_mul(input logic m);
`ifdef FP_MUL_EN
    return m;
`else
    return 1'b0 & m;
`endif
  endfunction

  function automatic logic [31:0] rand_f(input int ne);
    int          c, e;
    logic [22:0] fr;
    c  = int'($urandom_range(0, 19));
    fr = 23'($urandom);
    if ($urandom_range(0, 3) == 0) fr[10:0] = 11'h0;
    e  = ne + int'($urandom_range(0, 8)) - 4;
    if (c == 0) return {1'($urandom), 8'h00, ($urandom_range(0, 1) == 0) ? fr : 23'h0};
    if (c == 1) return {1'($urandom), 8'hFF, 23'h0};
    if (c == 2) return {1'($urandom), 8'hFF, fr | 23'h1};
    if (c == 3) e = int'($urandom_range(1, 254));
    if (e < 1)   e = 1;
    if (e > 254) e = 254;
    return {1'($urandom), 8'(e), fr};
  endfunction

  // ---------------- stimulus ----------------
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic mul,
                       input bit push);
    int n;
    @(negedge clk);
    input_a = a; op_mul = mul; input_a_stb = 1'b1;
    n = 0;
    while (!input_a_ack && n < 300) begin @(negedge clk); n++; end
    if (!input_a_ack) chk("a_ack_timeout", {31'h0, input_a_ack}, 32'h1);
    @(posedge clk); #1;
    input_a_stb = 1'b0; op_mul = 1'($urandom); input_a = $urandom;
    @(negedge clk);
    input_b = b; input_b_stb = 1'b1;
    n = 0;
    while (!input_b_ack && n < 300) begin @(negedge clk); n++; end
    if (!input_b_ack) chk("b_ack_timeout", {31'h0, input_b_ack}, 32'h1);
    @(posedge clk); #1;
    input_b_stb = 1'b0; input_b = $urandom;
    if (push) begin
      exp_z.push_back(ref_model(a, b, eff_mul(mul)));
      exp_t.push_back(cyc + 6);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    bit          seen, acked;
    int          held;
    logic [31:0] zhold, ez;
    int unsigned et;
    seen = 0; acked = 0; held = 0; zhold = 0;
    output_z_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        output_z_ack = 1'b0; seen = 0; acked = 0;
      end else if (acked) begin
        chk("stb_drop_after_ack", {31'h0, output_z_stb}, 32'h0);
        chk("a_ack_after_z", {31'h0, input_a_ack}, 32'h1);
        output_z_ack = 1'b0; acked = 0; seen = 0; hold_req = 0;
      end else if (output_z_stb) begin
        if (!seen) begin
          seen = 1; held = 0; zhold = output_z;
          if (exp_z.size() == 0) begin
            chk("unexpected_result", output_z_stb, 32'h0);
          end else begin
            ez = exp_z.pop_front();
            et = exp_t.pop_front();
            chk("result", output_z, ez);
            chk("latency", cyc, et);
          end
        end else begin
          chk("z_hold", output_z, zhold);
        end
        held++;
        if (held > hold_req && (hold_req > 0 || $urandom_range(0, 2) == 0)) begin
          output_z_ack = 1'b1; acked = 1;
        end
      end else if (seen) begin
        chk("stb_held_without_ack", {31'h0, output_z_stb}, 32'h1);
        seen = 0;
      end
    end
  end

  logic [31:0] dir_a [12] = '{32'h4040_0000, 32'h4040_0000, 32'h4100_0000, 32'h3F80_0000,
                              32'h3F80_0000, 32'h7F80_0000, 32'h7F00_0000, 32'h0000_0001,
                              32'h8000_0000, 32'h0000_0000, 32'h7FC0_0001, 32'h7F80_0000};
  logic [31:0] dir_b [12] = '{32'h4100_0000, 32'h4178_0000, 32'hC100_0000, 32'h3380_0000,
                              32'h3440_0000, 32'hFF80_0000, 32'h4000_0000, 32'h3F80_0000,
                              32'h8000_0000, 32'h8000_0000, 32'h3F80_0000, 32'h0000_0000};
  logic        dir_m [12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                              1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin : stim
    logic [31:0] a, b;
    int          n;
    rst_n = 1'b0; op_mul = 1'b0;
    input_a = 32'h0; input_a_stb = 1'b0; input_b = 32'h0; input_b_stb = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_ack", {31'h0, input_a_ack}, 32'h0);
    chk("rst_b_ack", {31'h0, input_b_ack}, 32'h0);
    chk("rst_z_stb", {31'h0, output_z_stb}, 32'h0);
    chk("rst_z", output_z, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_a_ack", {31'h0, input_a_ack}, 32'h1);

    for (int i = 0; i < 12; i++) begin
      if (i == 1) hold_req = 10;
      do_op(dir_a[i], dir_b[i], dir_m[i], 1'b1);
    end

    // Reset while waiting for B: acks must drop without a clock edge
    @(negedge clk);
    input_a = 32'h3F80_0000; input_a_stb = 1'b1;
    n = 0;
    while (!input_a_ack && n < 300) begin @(negedge clk); n++; end
    @(posedge clk); #1 input_a_stb = 1'b0;
    n = 0;
    @(negedge clk);
    while (!input_b_ack && n < 300) begin @(negedge clk); n++; end
    chk("b_ack_before_rst", {31'h0, input_b_ack}, 32'h1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_b_ack", {31'h0, input_b_ack}, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // Reset during NORM discards the in-flight result and clears output_z
    do_op(32'h4040_0000, 32'h4178_0000, 1'b0, 1'b1);
    do_op(32'h4120_0000, 32'h4080_0000, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("norm_rst_a_ack", {31'h0, input_a_ack}, 32'h0);
    chk("norm_rst_z_stb", {31'h0, output_z_stb}, 32'h0);
    chk("norm_rst_z", output_z, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    do_op(32'h4040_0000, 32'h4100_0000, 1'b1, 1'b1);

    for (int i = 0; i < 300; i++) begin
      a = rand_f(int'($urandom_range(90, 164)));
      case ($urandom_range(0, 9))
        0:       b = a ^ 32'h8000_0000;
        1:       b = (a ^ 32'h8000_0000) ^ 32'($urandom_range(1, 15));
        default: b = rand_f(int'({24'h0, a[30:23]}));
      endcase
      do_op(a, b, 1'($urandom), 1'b1);
    end

    n = 0;
    while ((exp_z.size() != 0 || output_z_stb) && n < 2000) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk("drain", exp_z.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
